psimd_wb_sequencer: RTL and testbench
=====================================

Name: psimd_wb_sequencer

Overview:
- Writeback-side producer for the PSIMD register file write port. It buffers results from the PSIMD execute stage and drives wr_enable, rd_address, logic_fti_ctrl, dataout_1 and dataout_2 into the register file, one entry per cycle.
- Result types are single 64-bit writes (rd) and paired 128-bit writes (rd and rd+1).
- Exports a pending-destination mask so issue logic can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- AW, 5, register address width (32 registers).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- res_valid  input  1  execute result valid
- res_ready  output  1  sequencer can accept a result
- res_rd  input  AW  destination register
- res_pair  input  1  1 = paired write (rd, rd+1); 0 = single write
- res_lo  input  64  data for rd
- res_hi  input  64  data for rd+1; ignored when res_pair=0
- wb_stall  input  1  write port held by another master this cycle
- wr_enable  output  1  register file write strobe
- rd_address  output  AW  register file write address
- logic_fti_ctrl  output  1  1 = single write, 0 = paired write
- dataout_1  output  64  data to rd_address
- dataout_2  output  64  data to rd_address+1
- pending_mask  output  32  bit r set if any queued entry targets r
- occupancy  output  $clog2(DEPTH)+1  queued entry count
- pair_wrap_err  output  1  sticky: a paired write to rd=31 was received

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Read pointer, write pointer and count cleared to 0; FIFO storage contents are don't-care.
  - pair_wrap_err cleared to 0.
  - Resulting outputs: res_ready=1, wr_enable=0, occupancy=0, pending_mask=0.
  - Reset mid-operation discards all queued entries; nothing queued before reset is ever written.
- Push:
  - res_ready = (count != DEPTH). There is no push-when-full-with-pop bypass.
  - On a clk edge with res_valid && res_ready, {res_rd, res_pair, res_lo, res_hi} is stored at the write pointer; the write pointer advances modulo DEPTH.
- Pair wrap:
  - If res_pair=1 and res_rd=31, the entry is stored as a single write (pair bit forced 0, res_hi dropped) and pair_wrap_err is set.
  - pair_wrap_err stays set until reset.
- Head drive (combinational from the FIFO head):
  - wr_enable = (count != 0) && !wb_stall.
  - rd_address = head rd; logic_fti_ctrl = !head pair; dataout_1 = head lo.
  - dataout_2 = head hi for pair entries, 64'b0 for single entries.
  - When count == 0: rd_address, dataout_1 and dataout_2 are 0 and logic_fti_ctrl is 1.
- Pop:
  - On a clk edge with wr_enable=1, the read pointer advances modulo DEPTH.
  - wb_stall=1 holds the head and all outputs unchanged.
- Latency and throughput:
  - A result accepted at edge N into an empty FIFO drives wr_enable in cycle N+1 (the cycle after edge N); the register file commits it at edge N+1+k, where k is the number of stalled cycles.
  - Sustained throughput is 1 entry per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO cannot pop in the same cycle; no fall-through.
- Ordering: strictly FIFO. Multiple entries to the same rd are all written, in order, so the last accepted entry wins.
- pending_mask:
  - OR over all valid entries of the bit for rd, plus the bit for rd+1 when pair=1.
  - Combinational from storage and count; excludes the incoming result on res_*.
  - A bit clears in the cycle after the edge that pops the last entry referencing that register.
- occupancy equals count, range 0..DEPTH.

Test Plan:
- Reset, then push single rd=5, lo=64'hA5 -> next cycle: wr_enable=1, rd_address=5, logic_fti_ctrl=1, dataout_1=64'hA5, dataout_2=0, pending_mask=32'h20; the following cycle: wr_enable=0, pending_mask=0.
- Push pair rd=8, lo=64'h1111, hi=64'h2222 -> wr_enable=1, logic_fti_ctrl=0, rd_address=8, dataout_2=64'h2222, pending_mask=32'h300.
- Hold wb_stall=1, push 5 results with DEPTH=4 -> res_ready=0 after the 4th accept, occupancy=4. Release the stall -> 4 writes on consecutive cycles in push order, res_ready returns to 1 in the cycle after the first pop.
- Push pair rd=31 -> pair_wrap_err=1, single write to 31 with logic_fti_ctrl=1, pending_mask=32'h8000_0000. pair_wrap_err remains 1 after the write, and clears only on rst_n=0.
- Push stream at full rate with no stalls -> occupancy stays at 1, one write per cycle, no entries lost, data matches the scoreboard.
- Fill 3 entries, assert rst_n=0 for one edge -> occupancy=0, wr_enable=0, pending_mask=0; none of the 3 entries ever writes.

Source files
------------

// File: rtl/psimd_wb_sequencer.sv
// Writeback sequencer: buffers PSIMD execute results in a small FIFO and drives
// the register-file write port one entry per cycle, exporting a pending-destination mask.
module psimd_wb_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [AW-1:0]          res_rd,
    input  logic                   res_pair,
    input  logic [63:0]            res_lo,
    input  logic [63:0]            res_hi,
    input  logic                   wb_stall,
    output logic                   wr_enable,
    output logic [AW-1:0]          rd_address,
    output logic                   logic_fti_ctrl,
    output logic [63:0]            dataout_1,
    output logic [63:0]            dataout_2,
    output logic [31:0]            pending_mask,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   pair_wrap_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] rd_mem   [DEPTH];
    logic          pair_mem [DEPTH];
    logic [63:0]   lo_mem   [DEPTH];
    logic [63:0]   hi_mem   [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;
    logic wrap;
    logic pair_in;
    logic empty;

    assign empty     = (count == '0);
    assign res_ready = (count != CW'(DEPTH));
    assign push      = res_valid && res_ready;
    assign wr_enable = !empty && !wb_stall;
    assign pop       = wr_enable;
    assign occupancy = count;

    // A pair to r31 would spill past the register file; keep only the low half.
    assign wrap    = res_pair && (res_rd == AW'(31));
    assign pair_in = res_pair && !wrap;

    // NOTE: storage has no reset; validity is tracked solely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= res_rd;
            pair_mem[wr_ptr] <= pair_in;
            lo_mem[wr_ptr]   <= res_lo;
            hi_mem[wr_ptr]   <= pair_in ? res_hi : 64'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pair_wrap_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && wrap) pair_wrap_err <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        rd_address     = '0;
        logic_fti_ctrl = 1'b1;
        dataout_1      = 64'b0;
        dataout_2      = 64'b0;
        if (!empty) begin
            rd_address     = rd_mem[rd_ptr];
            logic_fti_ctrl = !pair_mem[rd_ptr];
            dataout_1      = lo_mem[rd_ptr];
            dataout_2      = pair_mem[rd_ptr] ? hi_mem[rd_ptr] : 64'b0;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] offset;
        pending_mask = '0;
        offset       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if ({1'b0, offset} < count) begin
                pending_mask[rd_mem[i]] = 1'b1;
                if (pair_mem[i]) pending_mask[rd_mem[i] + AW'(1)] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psimd_wb_sequencer.sv
// Directed self-checking bench for psimd_wb_sequencer (DEPTH=4, AW=5).
module tb_psimd_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_rd;
    logic        res_pair;
    logic [63:0] res_lo;
    logic [63:0] res_hi;
    logic        wb_stall;
    logic        wr_enable;
    logic [4:0]  rd_address;
    logic        logic_fti_ctrl;
    logic [63:0] dataout_1;
    logic [63:0] dataout_2;
    logic [31:0] pending_mask;
    logic [2:0]  occupancy;
    logic        pair_wrap_err;

    int checks = 0;
    int errors = 0;

    psimd_wb_sequencer #(.DEPTH(4), .AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_rd         (res_rd),
        .res_pair       (res_pair),
        .res_lo         (res_lo),
        .res_hi         (res_hi),
        .wb_stall       (wb_stall),
        .wr_enable      (wr_enable),
        .rd_address     (rd_address),
        .logic_fti_ctrl (logic_fti_ctrl),
        .dataout_1      (dataout_1),
        .dataout_2      (dataout_2),
        .pending_mask   (pending_mask),
        .occupancy      (occupancy),
        .pair_wrap_err  (pair_wrap_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] s_rd(input int k);
        return 5'(k + 1);
    endfunction
    function automatic logic s_pair(input int k);
        return k[0];
    endfunction
    function automatic logic [63:0] s_lo(input int k);
        return 64'h1000 + 64'(k * 3);
    endfunction

    initial begin
        logic [31:0] exp_mask;
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_rd    = '0;
        res_pair  = 1'b0;
        res_lo    = '0;
        res_hi    = '0;
        wb_stall  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_occ",   occupancy, 3'd0);
        check("rst_ready", res_ready, 1'b1);
        check("rst_wr",    wr_enable, 1'b0);
        check("rst_mask",  pending_mask, 32'h0);
        check("rst_err",   pair_wrap_err, 1'b0);
        check("rst_fti",   logic_fti_ctrl, 1'b1);
        check("rst_addr",  rd_address, 5'd0);

        // Single write, hi must be ignored.
        res_valid = 1'b1; res_rd = 5'd5; res_pair = 1'b0; res_lo = 64'hA5; res_hi = 64'hFFFF;
        tick();
        res_valid = 1'b0;
        #1;
        check("s_wr",   wr_enable, 1'b1);
        check("s_addr", rd_address, 5'd5);
        check("s_fti",  logic_fti_ctrl, 1'b1);
        check("s_d1",   dataout_1, 64'hA5);
        check("s_d2",   dataout_2, 64'h0);
        check("s_mask", pending_mask, 32'h20);
        tick();
        check("s_wr_after",   wr_enable, 1'b0);
        check("s_mask_after", pending_mask, 32'h0);

        // Paired write.
        res_valid = 1'b1; res_rd = 5'd8; res_pair = 1'b1; res_lo = 64'h1111; res_hi = 64'h2222;
        tick();
        res_valid = 1'b0;
        #1;
        check("p_wr",   wr_enable, 1'b1);
        check("p_fti",  logic_fti_ctrl, 1'b0);
        check("p_addr", rd_address, 5'd8);
        check("p_d1",   dataout_1, 64'h1111);
        check("p_d2",   dataout_2, 64'h2222);
        check("p_mask", pending_mask, 32'h300);
        tick();
        check("p_occ_after", occupancy, 3'd0);

        // Fill under stall, fifth attempt refused.
        wb_stall = 1'b1;
        res_pair = 1'b0;
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1; res_rd = 5'(10 + i); res_lo = 64'(100 + i);
            #1;
            check("f_ready", res_ready, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        res_valid = 1'b0;
        #1;
        check("f_occ",   occupancy, 3'd4);
        check("f_ready_full", res_ready, 1'b0);
        check("f_wr_stalled", wr_enable, 1'b0);
        check("f_head",  rd_address, 5'd10);
        check("f_mask",  pending_mask, 32'h3C00);
        tick();
        check("f_hold_occ",  occupancy, 3'd4);
        check("f_hold_head", dataout_1, 64'd100);
        wb_stall = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            check("d_wr",    wr_enable, 1'b1);
            check("d_addr",  rd_address, 5'(10 + j));
            check("d_d1",    dataout_1, 64'(100 + j));
            check("d_ready", res_ready, (j == 0) ? 1'b0 : 1'b1);
            tick();
        end
        check("d_wr_end", wr_enable, 1'b0);
        check("d_occ_end", occupancy, 3'd0);

        // Pair to r31 is demoted to single and flags the sticky error.
        res_valid = 1'b1; res_rd = 5'd31; res_pair = 1'b1; res_lo = 64'hDEAD; res_hi = 64'hBEEF;
        tick();
        res_valid = 1'b0;
        #1;
        check("w_err",  pair_wrap_err, 1'b1);
        check("w_wr",   wr_enable, 1'b1);
        check("w_addr", rd_address, 5'd31);
        check("w_fti",  logic_fti_ctrl, 1'b1);
        check("w_d1",   dataout_1, 64'hDEAD);
        check("w_d2",   dataout_2, 64'h0);
        check("w_mask", pending_mask, 32'h8000_0000);
        tick();
        tick();
        check("w_err_sticky", pair_wrap_err, 1'b1);
        check("w_wr_after",   wr_enable, 1'b0);

        // Full-rate stream: each entry is written the cycle after it is accepted.
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                exp_mask = 32'h1 << s_rd(k - 1);
                if (s_pair(k - 1)) exp_mask |= 32'h1 << (s_rd(k - 1) + 5'd1);
                check("st_occ",  occupancy, 3'd1);
                check("st_wr",   wr_enable, 1'b1);
                check("st_addr", rd_address, s_rd(k - 1));
                check("st_fti",  logic_fti_ctrl, !s_pair(k - 1));
                check("st_d1",   dataout_1, s_lo(k - 1));
                check("st_d2",   dataout_2, s_pair(k - 1) ? ~s_lo(k - 1) : 64'h0);
                check("st_mask", pending_mask, exp_mask);
            end
            if (k < 10) begin
                res_valid = 1'b1; res_rd = s_rd(k); res_pair = s_pair(k);
                res_lo = s_lo(k); res_hi = ~s_lo(k);
            end else begin
                res_valid = 1'b0;
            end
            tick();
        end
        check("st_occ_end", occupancy, 3'd0);

        // Reset mid-operation discards queued entries.
        wb_stall = 1'b1;
        res_pair = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_rd = 5'(20 + i); res_lo = 64'(i);
            tick();
        end
        res_valid = 1'b0;
        #1;
        check("r_occ_pre", occupancy, 3'd3);
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        wb_stall = 1'b0;
        #1;
        check("r_occ",  occupancy, 3'd0);
        check("r_wr",   wr_enable, 1'b0);
        check("r_mask", pending_mask, 32'h0);
        check("r_err",  pair_wrap_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r_no_write", wr_enable, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
